// File: rtl/vid_colour_bbox_pkg.sv
// Shared types and constants for the colour bounding-box video stage.
// Pixel layout, packet-type nibble, overlay colour and FSM states.
package vid_colour_bbox_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    localparam logic [3:0]  PKT_VIDEO   = 4'h0;
    localparam logic [23:0] OVERLAY_RGB = 24'hFF0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_VIDEO,
        ST_CTRL
    } state_t;

endpackage

// File: rtl/vid_colour_bbox_cmp.sv
// Combinational per-channel inclusive range test for one RGB888 pixel.
// An inverted range on any channel can never produce a hit.
module rgb_thresh_cmp
    import vid_colour_bbox_pkg::*;
(
    input  rgb888_t i_pix,
    input  rgb888_t i_min,
    input  rgb888_t i_max,
    output logic    o_hit
);

    logic w_r_ok;
    logic w_g_ok;
    logic w_b_ok;

    assign w_r_ok = (i_pix.r >= i_min.r) && (i_pix.r <= i_max.r);
    assign w_g_ok = (i_pix.g >= i_min.g) && (i_pix.g <= i_max.g);
    assign w_b_ok = (i_pix.b >= i_min.b) && (i_pix.b <= i_max.b);
    assign o_hit  = w_r_ok && w_g_ok && w_b_ok;

endmodule

// File: rtl/vid_colour_bbox.sv
// Avalon-ST pass-through stage measuring the bbox/hit count of in-range pixels.
// Define VID_COLOUR_BBOX_OVERLAY_EN to draw the last committed bbox on the video.
module vid_colour_bbox
    import vid_colour_bbox_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int CNT_W = 19
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [23:0]      sink_data,
    input  logic             sink_valid,
    input  logic             sink_sop,
    input  logic             sink_eop,
    output logic             sink_ready,
    output logic [23:0]      source_data,
    output logic             source_valid,
    output logic             source_sop,
    output logic             source_eop,
    input  logic             source_ready,
    input  logic [23:0]      thr_min,
    input  logic [23:0]      thr_max,
    output logic [9:0]       bbox_xmin,
    output logic [9:0]       bbox_xmax,
    output logic [8:0]       bbox_ymin,
    output logic [8:0]       bbox_ymax,
    output logic [CNT_W-1:0] hit_count,
    output logic             bbox_valid
);

    localparam logic [9:0] X_LAST = 10'(IMG_W - 1);
    localparam logic [8:0] Y_LAST = 9'(IMG_H - 1);

    state_t           r_state;
    logic [9:0]       r_x;
    logic [8:0]       r_y;
    logic             r_full;
    logic [9:0]       r_acc_xmin;
    logic [9:0]       r_acc_xmax;
    logic [8:0]       r_acc_ymin;
    logic [8:0]       r_acc_ymax;
    logic [CNT_W-1:0] r_acc_cnt;

    logic [23:0]      r_src_data;
    logic             r_src_valid;
    logic             r_src_sop;
    logic             r_src_eop;
    logic [9:0]       r_bbox_xmin;
    logic [9:0]       r_bbox_xmax;
    logic [8:0]       r_bbox_ymin;
    logic [8:0]       r_bbox_ymax;
    logic [CNT_W-1:0] r_hit_count;
    logic             r_bbox_valid;

    logic             w_xfer;
    logic             w_is_pix;
    logic             w_cmp_hit;
    logic             w_hit;
    logic [23:0]      w_out_data;
    logic [9:0]       w_nx_xmin;
    logic [9:0]       w_nx_xmax;
    logic [8:0]       w_nx_ymin;
    logic [8:0]       w_nx_ymax;
    logic [CNT_W-1:0] w_nx_cnt;

    assign sink_ready = source_ready | ~r_src_valid;
    assign w_xfer     = sink_valid & sink_ready;
    // Pixels past the last active position are forwarded but never analysed
    assign w_is_pix   = (r_state == ST_VIDEO) & ~sink_sop & ~r_full;
    assign w_hit      = w_is_pix & w_cmp_hit;

    rgb_thresh_cmp u_cmp (
        .i_pix (rgb888_t'(sink_data)),
        .i_min (rgb888_t'(thr_min)),
        .i_max (rgb888_t'(thr_max)),
        .o_hit (w_cmp_hit)
    );

    assign w_nx_xmin = (w_hit && r_x < r_acc_xmin) ? r_x : r_acc_xmin;
    assign w_nx_xmax = (w_hit && r_x > r_acc_xmax) ? r_x : r_acc_xmax;
    assign w_nx_ymin = (w_hit && r_y < r_acc_ymin) ? r_y : r_acc_ymin;
    assign w_nx_ymax = (w_hit && r_y > r_acc_ymax) ? r_y : r_acc_ymax;
    assign w_nx_cnt  = (w_hit && r_acc_cnt != '1) ?
                       r_acc_cnt + CNT_W'(1) : r_acc_cnt;

`ifdef VID_COLOUR_BBOX_OVERLAY_EN
    logic w_x_in;
    logic w_y_in;
    logic w_border;

    assign w_x_in   = (r_x >= r_bbox_xmin) && (r_x <= r_bbox_xmax);
    assign w_y_in   = (r_y >= r_bbox_ymin) && (r_y <= r_bbox_ymax);
    assign w_border = w_is_pix && (r_hit_count != '0) &&
                      ((((r_x == r_bbox_xmin) || (r_x == r_bbox_xmax)) && w_y_in) ||
                       (((r_y == r_bbox_ymin) || (r_y == r_bbox_ymax)) && w_x_in));
    assign w_out_data = w_border ? OVERLAY_RGB : sink_data;
`else
    assign w_out_data = sink_data;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_x          <= '0;
            r_y          <= '0;
            r_full       <= 1'b0;
            r_acc_xmin   <= '1;
            r_acc_xmax   <= '0;
            r_acc_ymin   <= '1;
            r_acc_ymax   <= '0;
            r_acc_cnt    <= '0;
            r_src_data   <= '0;
            r_src_valid  <= 1'b0;
            r_src_sop    <= 1'b0;
            r_src_eop    <= 1'b0;
            r_bbox_xmin  <= '0;
            r_bbox_xmax  <= '0;
            r_bbox_ymin  <= '0;
            r_bbox_ymax  <= '0;
            r_hit_count  <= '0;
            r_bbox_valid <= 1'b0;
        end else begin
            r_bbox_valid <= 1'b0;
            if (w_xfer) begin
                r_src_data  <= w_out_data;
                r_src_valid <= 1'b1;
                r_src_sop   <= sink_sop;
                r_src_eop   <= sink_eop;
            end else if (source_ready) begin
                r_src_valid <= 1'b0;
            end
            if (w_xfer && sink_sop) begin
                // Any sop abandons the current packet without a commit
                r_x        <= '0;
                r_y        <= '0;
                r_full     <= 1'b0;
                r_acc_xmin <= '1;
                r_acc_xmax <= '0;
                r_acc_ymin <= '1;
                r_acc_ymax <= '0;
                r_acc_cnt  <= '0;
                if (sink_eop)
                    r_state <= ST_IDLE;
                else if (sink_data[3:0] == PKT_VIDEO)
                    r_state <= ST_VIDEO;
                else
                    r_state <= ST_CTRL;
            end else if (w_xfer) begin
                unique case (r_state)
                    ST_IDLE: r_state <= ST_IDLE;
                    ST_CTRL: begin
                        if (sink_eop)
                            r_state <= ST_IDLE;
                    end
                    ST_VIDEO: begin
                        r_acc_xmin <= w_nx_xmin;
                        r_acc_xmax <= w_nx_xmax;
                        r_acc_ymin <= w_nx_ymin;
                        r_acc_ymax <= w_nx_ymax;
                        r_acc_cnt  <= w_nx_cnt;
                        if (!r_full) begin
                            if (r_x == X_LAST) begin
                                r_x <= '0;
                                if (r_y == Y_LAST)
                                    r_full <= 1'b1;
                                else
                                    r_y <= r_y + 9'd1;
                            end else begin
                                r_x <= r_x + 10'd1;
                            end
                        end
                        if (sink_eop) begin
                            r_state      <= ST_IDLE;
                            r_bbox_valid <= 1'b1;
                            r_hit_count  <= w_nx_cnt;
                            if (w_nx_cnt == '0) begin
                                r_bbox_xmin <= '0;
                                r_bbox_xmax <= '0;
                                r_bbox_ymin <= '0;
                                r_bbox_ymax <= '0;
                            end else begin
                                r_bbox_xmin <= w_nx_xmin;
                                r_bbox_xmax <= w_nx_xmax;
                                r_bbox_ymin <= w_nx_ymin;
                                r_bbox_ymax <= w_nx_ymax;
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign source_data  = r_src_data;
    assign source_valid = r_src_valid;
    assign source_sop   = r_src_sop;
    assign source_eop   = r_src_eop;
    assign bbox_xmin    = r_bbox_xmin;
    assign bbox_xmax    = r_bbox_xmax;
    assign bbox_ymin    = r_bbox_ymin;
    assign bbox_ymax    = r_bbox_ymax;
    assign hit_count    = r_hit_count;
    assign bbox_valid   = r_bbox_valid;

endmodule

// File: tb/tb_vid_colour_bbox.sv
// Scoreboard bench for vid_colour_bbox on a 4x2 image with a 3-bit counter.
// Define VID_COLOUR_BBOX_OVERLAY_EN to also model and test the overlay.
module tb_vid_colour_bbox;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int CW = 3;
`ifdef VID_COLOUR_BBOX_OVERLAY_EN
    localparam bit OVL = 1'b1;
`else
    localparam bit OVL = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [23:0]   sink_data;
    logic          sink_valid;
    logic          sink_sop;
    logic          sink_eop;
    logic          sink_ready;
    logic [23:0]   source_data;
    logic          source_valid;
    logic          source_sop;
    logic          source_eop;
    logic          source_ready;
    logic [23:0]   thr_min;
    logic [23:0]   thr_max;
    logic [9:0]    bbox_xmin;
    logic [9:0]    bbox_xmax;
    logic [8:0]    bbox_ymin;
    logic [8:0]    bbox_ymax;
    logic [CW-1:0] hit_count;
    logic          bbox_valid;

    typedef struct {
        logic        sop;
        logic        eop;
        logic [23:0] data;
    } beat_t;

    typedef struct {
        int xmin;
        int xmax;
        int ymin;
        int ymax;
        int cnt;
    } box_t;

    beat_t       exp_q[$];
    box_t        box_q[$];
    box_t        m_box;
    logic [23:0] fpx[$];
    int          checks = 0;
    int          errors = 0;
    bit          stall_prev = 1'b0;
    beat_t       prev_b;

    vid_colour_bbox #(.IMG_W(W), .IMG_H(H), .CNT_W(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .sink_data    (sink_data),
        .sink_valid   (sink_valid),
        .sink_sop     (sink_sop),
        .sink_eop     (sink_eop),
        .sink_ready   (sink_ready),
        .source_data  (source_data),
        .source_valid (source_valid),
        .source_sop   (source_sop),
        .source_eop   (source_eop),
        .source_ready (source_ready),
        .thr_min      (thr_min),
        .thr_max      (thr_max),
        .bbox_xmin    (bbox_xmin),
        .bbox_xmax    (bbox_xmax),
        .bbox_ymin    (bbox_ymin),
        .bbox_ymax    (bbox_ymax),
        .hit_count    (hit_count),
        .bbox_valid   (bbox_valid)
    );

    always #5 clk = ~clk;

    function automatic bit px_hit(input logic [23:0] p, lo, hi);
        logic [7:0] v, a, b;
        for (int c = 0; c < 3; c++) begin
            v = p[8*c +: 8];
            a = lo[8*c +: 8];
            b = hi[8*c +: 8];
            if (v < a || v > b) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic bit on_border(input int x, y);
        bit xin, yin;
        if (m_box.cnt == 0) return 1'b0;
        xin = x >= m_box.xmin && x <= m_box.xmax;
        yin = y >= m_box.ymin && y <= m_box.ymax;
        return ((x == m_box.xmin || x == m_box.xmax) && yin) ||
               ((y == m_box.ymin || y == m_box.ymax) && xin);
    endfunction

    // Scoreboard monitor: source beats, stall stability, and commits
    always @(negedge clk) begin
        beat_t e;
        box_t  b;
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev && source_valid) begin
                checks++;
                if ({source_sop, source_eop, source_data} !==
                    {prev_b.sop, prev_b.eop, prev_b.data}) begin
                    errors++;
                    $display("FAIL stall_hold got %h required %h",
                             source_data, prev_b.data);
                end
            end
            if (source_valid && source_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL src_beat got %h with nothing expected",
                             source_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({source_sop, source_eop, source_data} !==
                        {e.sop, e.eop, e.data}) begin
                        errors++;
                        $display("FAIL src_beat got sop%b eop%b %h required sop%b eop%b %h",
                                 source_sop, source_eop, source_data,
                                 e.sop, e.eop, e.data);
                    end
                end
            end
            stall_prev  = source_valid && !source_ready;
            prev_b.sop  = source_sop;
            prev_b.eop  = source_eop;
            prev_b.data = source_data;
            if (bbox_valid) begin
                checks++;
                if (box_q.size() == 0) begin
                    errors++;
                    $display("FAIL commit got unexpected bbox_valid count %0d",
                             hit_count);
                end else begin
                    b = box_q.pop_front();
                    if (bbox_xmin !== 10'(b.xmin) || bbox_xmax !== 10'(b.xmax) ||
                        bbox_ymin !== 9'(b.ymin) || bbox_ymax !== 9'(b.ymax) ||
                        hit_count !== CW'(b.cnt)) begin
                        errors++;
                        $display("FAIL commit got %0d..%0d,%0d..%0d n%0d required %0d..%0d,%0d..%0d n%0d",
                                 bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax,
                                 hit_count, b.xmin, b.xmax, b.ymin, b.ymax, b.cnt);
                    end
                end
            end
        end
    end

    task automatic drive_beat(input logic [23:0] d, input logic sop, eop,
                              input logic [23:0] exp_d);
        bit ok;
        ok = 1'b0;
        sink_data  = d;
        sink_sop   = sop;
        sink_eop   = eop;
        sink_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sink_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout got sink_ready 0 required 1");
        end else begin
            @(posedge clk);
            #1;
            exp_q.push_back('{sop, eop, exp_d});
        end
        sink_valid = 1'b0;
    endtask

    task automatic send_video(input bit with_eop);
        int n, cnt, xmn, xmx, ymn, ymx, x, y;
        bit last;
        logic [23:0] e;
        box_t m;
        n = fpx.size();
        cnt = 0; xmn = 1023; xmx = 0; ymn = 511; ymx = 0;
        drive_beat(24'h000000, 1'b1, 1'b0, 24'h000000);
        for (int i = 0; i < n; i++) begin
            x = i % W;
            y = i / W;
            last = with_eop && (i == n - 1);
            e = fpx[i];
            if (OVL && i < W * H && on_border(x, y)) e = 24'hFF0000;
            if (i < W * H && px_hit(fpx[i], thr_min, thr_max)) begin
                cnt++;
                if (x < xmn) xmn = x;
                if (x > xmx) xmx = x;
                if (y < ymn) ymn = y;
                if (y > ymx) ymx = y;
            end
            drive_beat(fpx[i], 1'b0, last, e);
        end
        if (with_eop) begin
            if (cnt > (1 << CW) - 1) cnt = (1 << CW) - 1;
            if (cnt == 0) m = '{0, 0, 0, 0, 0};
            else m = '{xmn, xmx, ymn, ymx, cnt};
            box_q.push_back(m);
            m_box = m;
        end
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || box_q.size() != 0) && k < 50) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || box_q.size() != 0) begin
            errors++;
            $display("FAIL drain_%s got beats %0d boxes %0d required 0 0",
                     tag, exp_q.size(), box_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({source_valid, source_sop, source_eop, source_data} !== 27'd0) begin
            errors++;
            $display("FAIL reset_source got %b%b%b %h required 0",
                     source_valid, source_sop, source_eop, source_data);
        end
        checks++;
        if ({bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax, hit_count, bbox_valid}
            !== '0) begin
            errors++;
            $display("FAIL reset_bbox got %0d %0d %0d %0d %0d %b required 0",
                     bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax,
                     hit_count, bbox_valid);
        end
        checks++;
        if (sink_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b required 1", sink_ready);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_basic();
        thr_min = 24'h800000;
        thr_max = 24'hFFFFFF;
        fpx = '{24'h101010, 24'hFF0000, 24'h101010, 24'h7F0000,
                24'h101010, 24'h101010, 24'h101010, 24'hC00000};
        send_video(1'b1);
        @(negedge clk);
        checks++;
        if (bbox_valid !== 1'b1 || hit_count !== 3'd2 || bbox_xmin !== 10'd1 ||
            bbox_xmax !== 10'd3 || bbox_ymin !== 9'd0 || bbox_ymax !== 9'd1) begin
            errors++;
            $display("FAIL basic_commit got v%b n%0d %0d..%0d,%0d..%0d required v1 n2 1..3,0..1",
                     bbox_valid, hit_count, bbox_xmin, bbox_xmax,
                     bbox_ymin, bbox_ymax);
        end
        @(negedge clk);
        checks++;
        if (bbox_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_pulse got %b required 0", bbox_valid);
        end
        drain("basic");
    endtask

    task automatic test_ctrl();
        thr_min = 24'h800000;
        thr_max = 24'hFFFFFF;
        drive_beat(24'h00000F, 1'b1, 1'b0, 24'h00000F);
        drive_beat(24'hFF0000, 1'b0, 1'b0, 24'hFF0000);
        drive_beat(24'hFF0000, 1'b0, 1'b0, 24'hFF0000);
        drive_beat(24'hFF0000, 1'b0, 1'b1, 24'hFF0000);
        fpx = '{default: 24'h000000};
        fpx = {};
        for (int i = 0; i < W * H; i++) fpx.push_back(24'h000000);
        send_video(1'b1);
        drain("ctrl");
        checks++;
        if (hit_count !== 3'd0 || bbox_xmax !== 10'd0 || bbox_ymax !== 9'd0) begin
            errors++;
            $display("FAIL ctrl_zero got n%0d x%0d y%0d required 0 0 0",
                     hit_count, bbox_xmax, bbox_ymax);
        end
    endtask

    task automatic test_stall();
        bit done;
        done = 1'b0;
        thr_min = 24'h800000;
        thr_max = 24'hFFFFFF;
        fpx = {};
        for (int i = 0; i < W * H; i++) fpx.push_back(24'h900000 + 24'(i));
        fork
            begin
                send_video(1'b1);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    source_ready = ~source_ready;
                end
            end
        join
        source_ready = 1'b1;
        drain("stall");
    endtask

    task automatic test_abort();
        thr_min = 24'h800000;
        thr_max = 24'hFFFFFF;
        fpx = '{24'hFF0000, 24'hFF0000, 24'hFF0000};
        send_video(1'b0);
        fpx = {};
        for (int i = 0; i < W * H; i++)
            fpx.push_back(i == 6 ? 24'hA0A0A0 : 24'h202020);
        send_video(1'b1);
        drain("abort");
    endtask

    task automatic test_bounds();
        thr_min = 24'h102030;
        thr_max = 24'h405060;
        fpx = '{24'h102030, 24'h000000, 24'h000000, 24'h405060,
                24'h000000, 24'h0F2030, 24'h415060, 24'h000000,
                24'h203040, 24'h203040};
        send_video(1'b1);
        drain("bounds");
        thr_min = 24'h008000;
        thr_max = 24'hFF7FFF;
        fpx = {};
        for (int i = 0; i < W * H; i++) fpx.push_back(24'h808080 ^ 24'(i * 5));
        send_video(1'b1);
        drain("inverted");
    endtask

    task automatic test_back_to_back();
        thr_min = 24'h800000;
        thr_max = 24'hFFFFFF;
        drive_beat(24'hFF0000, 1'b0, 1'b0, 24'hFF0000);
        fpx = '{24'h000000, 24'hFF0000};
        send_video(1'b1);
        fpx = {};
        for (int i = 0; i < W * H; i++)
            fpx.push_back(i == 4 || i == 5 ? 24'hFFFFFF : 24'h7FFFFF);
        send_video(1'b1);
        drain("b2b");
    endtask

    task automatic test_reset_mid();
        thr_min = 24'h800000;
        thr_max = 24'hFFFFFF;
        fpx = '{24'hFF0000, 24'hFF0000, 24'hFF0000};
        send_video(1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        m_box = '{0, 0, 0, 0, 0};
        @(negedge clk);
        checks++;
        if (source_valid !== 1'b0 || hit_count !== 3'd0 || bbox_valid !== 1'b0 ||
            bbox_xmax !== 10'd0 || source_data !== 24'd0) begin
            errors++;
            $display("FAIL reset_mid got v%b n%0d bv%b x%0d d%h required 0",
                     source_valid, hit_count, bbox_valid, bbox_xmax, source_data);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        fpx = {};
        for (int i = 0; i < W * H; i++)
            fpx.push_back(i == 2 ? 24'hF00000 : 24'h000000);
        send_video(1'b1);
        drain("reset_mid");
    endtask

`ifdef VID_COLOUR_BBOX_OVERLAY_EN
    task automatic test_overlay();
        thr_min = 24'h800000;
        thr_max = 24'hFFFFFF;
        fpx = {};
        for (int i = 0; i < W * H; i++)
            fpx.push_back(i == 1 || i == 6 ? 24'hFF0000 : 24'h000000);
        send_video(1'b1);
        fpx = {};
        for (int i = 0; i < W * H; i++) fpx.push_back(24'h000000);
        send_video(1'b1);
        drain("overlay");
    endtask
`endif

    initial begin
        reset        = 1'b1;
        sink_data    = '0;
        sink_valid   = 1'b0;
        sink_sop     = 1'b0;
        sink_eop     = 1'b0;
        source_ready = 1'b1;
        thr_min      = '0;
        thr_max      = '0;
        m_box        = '{0, 0, 0, 0, 0};
        test_reset();
        test_basic();
        test_ctrl();
        test_stall();
        test_abort();
        test_bounds();
        test_back_to_back();
        test_reset_mid();
`ifdef VID_COLOUR_BBOX_OVERLAY_EN
        test_overlay();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
